// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB first, with a start/busy/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic [1:0]       state_dbg
);

   // Handshake: start is a request that is accepted on any rising edge where
   // busy=0 (IDLE or DONE); while busy=1 start is ignored. done pulses for
   // exactly one cycle when sum/cout/overflow have been updated.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic             carry_next;
   logic             bit_sum;
   logic             accept;
   logic             last_bit;
   logic [CW-1:0]    cnt;

   // Datapath: the single full-adder cell and the result shift.
   always_comb begin
      bit_sum    = a_reg[0] ^ b_reg[0] ^ carry;
      carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
      res_next   = res_reg >> 1;
      res_next[WIDTH-1] = bit_sum;
   end

   always_comb begin
      state_next = state;
      accept     = start && (state != BUSY);
      last_bit   = (state == BUSY) && (cnt == LAST);
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (last_bit) state_next = DONE;
         DONE:    state_next = accept ? BUSY : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         res_reg  <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            // Subtraction is a + ~b + ~borrow, so fold the inversion in at capture.
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            carry   <= cin ^ sub;
            res_reg <= '0;
            cnt     <= '0;
         end else if (state == BUSY) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            carry   <= carry_next;
            res_reg <= res_next;
            cnt     <= cnt + CW'(1);
            if (last_bit) begin
               // carry currently holds the carry into the MSB.
               sum      <= res_next;
               cout     <= carry_next;
               overflow <= carry ^ carry_next;
            end
         end
      end
   end

   assign busy      = (state == BUSY);
   assign done      = (state == DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a WIDTH=1 instance for half-adder
// equivalence and a WIDTH=8 instance for arithmetic, handshake and reset.
module tb_serial_adder;

   logic       clk;
   logic       rst;

   logic       start8, sub8, cin8;
   logic [7:0] a8, b8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;
   logic [1:0] st8;

   logic       start1, sub1, cin1;
   logic [0:0] a1, b1;
   logic       busy1, done1, cout1, ovf1;
   logic [0:0] sum1;
   logic [1:0] st1;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] last_sum8 = 8'h00;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8),
      .state_dbg(st8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1),
      .state_dbg(st1)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One 8-bit operation: start for one edge, scramble inputs, count busy cycles.
   task automatic run8(input string tag, input logic s, input logic [7:0] av,
                       input logic [7:0] bv, input logic c, input logic [7:0] es,
                       input logic ec, input logic eo);
      int n;
      sub8 = s; a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
      step();
      start8 = 1'b0;
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      sub8 = 1'($urandom_range(0, 1));
      check({tag, "_sum_hold"}, 32'(sum8), 32'(last_sum8));
      n = 0;
      while (busy8 && n < 20) begin
         n++;
         step();
      end
      check({tag, "_busy_cycles"}, n, 8);
      check({tag, "_done"}, 32'(done8), 1);
      check({tag, "_sum"}, 32'(sum8), 32'(es));
      check({tag, "_cout"}, 32'(cout8), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
      last_sum8 = es;
      step();
      check({tag, "_done_pulse"}, 32'({busy8, done8}), 0);
   endtask

   task automatic run1(input string tag, input logic av, input logic bv,
                       input logic es, input logic ec, input logic eo);
      int n;
      sub1 = 1'b0; cin1 = 1'b0; a1 = av; b1 = bv; start1 = 1'b1;
      step();
      start1 = 1'b0;
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      n = 0;
      while (busy1 && n < 10) begin
         n++;
         step();
      end
      check({tag, "_busy_cycles"}, n, 1);
      check({tag, "_done"}, 32'(done1), 1);
      check({tag, "_sum"}, 32'(sum1), 32'(es));
      check({tag, "_cout"}, 32'(cout1), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf1), 32'(eo));
      step();
      check({tag, "_done_pulse"}, 32'(done1), 0);
   endtask

   initial begin
      int n;
      int seen;
      rst = 1'b1;
      start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_busy8", 32'(busy8), 0);
      check("rst_done8", 32'(done8), 0);
      check("rst_sum8", 32'(sum8), 0);
      check("rst_flags8", 32'({cout8, ovf8}), 0);
      check("rst_state8", 32'(st8), 0);
      check("rst_out1", 32'({busy1, done1, sum1, cout1, ovf1}), 0);
      check("rst_state1", 32'(st1), 0);

      // Half-adder equivalence (WIDTH=1)
      run1("ha00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run1("ha01", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      run1("ha10", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      run1("ha11", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

      // Addition
      run8("wrap",    1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run8("sovf",    1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run8("add_cin", 1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);

      // Subtraction
      run8("sub_neg",    1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
      run8("sub_ovf",    1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
      run8("sub_borrow", 1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b0, 1'b0);

      // Handshake: start pulsed on BUSY cycle 3 must be ignored
      sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
      step();
      start8 = 1'b0;
      n = 0;
      while (busy8 && n < 20) begin
         n++;
         if (n == 3) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
         end else begin
            start8 = 1'b0;
         end
         step();
      end
      start8 = 1'b0;
      check("hs_ignore_busy_cycles", n, 8);
      check("hs_ignore_done", 32'(done8), 1);
      check("hs_ignore_sum", 32'(sum8), 32'h46);

      // Handshake: start held through done begins the next op immediately
      a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
      step();
      start8 = 1'b0;
      check("hs_b2b_busy", 32'(busy8), 1);
      check("hs_b2b_sum_hold", 32'(sum8), 32'h46);
      n = 1;
      while (!done8 && n < 20) begin
         n++;
         step();
      end
      check("hs_b2b_latency", n, 9);
      check("hs_b2b_sum", 32'(sum8), 32'h03);
      step();
      last_sum8 = 8'h03;

      // Leave nonzero flags behind so the reset clear is visible
      run8("pre_rst", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

      // Reset mid-operation
      sub8 = 1'b0; cin8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      step();
      start8 = 1'b0;
      step();
      step();
      step();
      check("mid_busy", 32'(busy8), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_busy_done", 32'({busy8, done8}), 0);
      check("mrst_sum", 32'(sum8), 0);
      check("mrst_flags", 32'({cout8, ovf8}), 0);
      check("mrst_state", 32'(st8), 0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) seen++;
         step();
      end
      check("mrst_no_done", seen, 0);
      last_sum8 = 8'h00;
      run8("post_rst", 1'b0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
